// File: rtl/mod12_run_ctrl.sv
// Run/pause/clear/load controller driving a prescaled modulo-MOD up/down counter.
// Start, stop and clear act on rising edges; all outputs are registered.
module mod12_run_ctrl #(
  parameter int DIV = 4,
  parameter int MOD = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dir,
  output logic [3:0] led,
  output logic       carry,
  output logic [1:0] state,
  output logic       load_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);
  localparam logic [3:0]  LED_LAST   = 4'(MOD - 1);
  localparam logic [4:0]  MOD_W      = 5'(MOD);

  state_t      cur, nxt;
  logic [15:0] presc, presc_nxt;
  logic [3:0]  led_nxt;
  logic        carry_nxt, err_nxt;
  logic        start_q, stop_q, clear_q;
  logic        start_e, stop_e, clear_e;
  logic        tick;

  assign start_e = start & ~start_q;
  assign stop_e  = stop & ~stop_q;
  assign clear_e = clear & ~clear_q;
  assign tick    = (cur == RUN) && (presc == PRESC_LAST);
  assign state   = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur      <= IDLE;
      presc    <= '0;
      led      <= '0;
      carry    <= 1'b0;
      load_err <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      cur      <= nxt;
      presc    <= presc_nxt;
      led      <= led_nxt;
      carry    <= carry_nxt;
      load_err <= err_nxt;
      start_q  <= start;
      stop_q   <= stop;
      clear_q  <= clear;
    end
  end

  // Clear overrides everything; a stop edge beats a start edge, and the
  // prescaler is frozen while pausing so a resume keeps the tick phase.
  always_comb begin
    nxt       = cur;
    presc_nxt = presc;
    led_nxt   = led;
    carry_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (clear_e) begin
      nxt       = IDLE;
      led_nxt   = '0;
      presc_nxt = '0;
    end else begin
      case (cur)
        IDLE: begin
          if (start_e && !stop_e) begin
            nxt       = RUN;
            presc_nxt = '0;
          end
        end
        RUN: begin
          if (tick) begin
            presc_nxt = '0;
            if (dir) begin
              if (led == LED_LAST) begin
                led_nxt   = '0;
                carry_nxt = 1'b1;
              end else begin
                led_nxt = led + 4'd1;
              end
            end else begin
              if (led == 4'd0) begin
                led_nxt   = LED_LAST;
                carry_nxt = 1'b1;
              end else begin
                led_nxt = led - 4'd1;
              end
            end
          end else if (!stop_e) begin
            presc_nxt = presc + 16'd1;
          end
          if (stop_e) nxt = PAUSE;
        end
        PAUSE: begin
          if (start_e && !stop_e) nxt = RUN;
        end
        default: nxt = IDLE;
      endcase
      if ((cur == IDLE || cur == PAUSE) && load) begin
        if ({1'b0, load_val} < MOD_W) led_nxt = load_val;
        else                          err_nxt = 1'b1;
      end
    end
  end

endmodule

// File: doc/mod12_run_ctrl.md
Name: mod12_run_ctrl

Overview:
- Run/pause/clear/load controller that sequences a modulo-12 counter, which sits in the display path and drives `led[3:0]`.
- Converts raw start/stop/clear strobes into a 3-state run FSM.
- Gates the count with a programmable prescaler tick, supports up/down counting and parallel load, and flags wrap-around with a carry pulse.
- Single clock domain; intended to replace free-running counter instances on the board top.

Parameters:
- DIV, default 4: prescaler ratio, one count step per DIV clocks in RUN; legal range 1..2^16-1.
- MOD, default 12: counter modulus; count range 0..MOD-1; legal 2..16.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run request, rising-edge sensitive.
- stop  input  1  pause request, rising-edge sensitive.
- clear  input  1  clear request, rising-edge sensitive.
- load  input  1  load strobe, level-sampled, honoured only in IDLE/PAUSE.
- load_val  input  4  value to load.
- dir  input  1  1 = count up, 0 = count down; sampled at each tick.
- led  output  4  current count, 0..MOD-1.
- carry  output  1  one-cycle pulse on wrap (up: MOD-1→0; down: 0→MOD-1).
- state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
- load_err  output  1  one-cycle pulse when a load is rejected because load_val ≥ MOD.

Behaviour:
- **Reset (reset=0, async):**
  - led=0, carry=0, load_err=0, state=IDLE, prescaler=0.
  - Edge-detect history registers = 0. Consequence: an input held high across reset release produces one edge.
- **Edge detect:** edge_x = x & ~x_q, where x_q is x registered each clk. A command is acted on at the same clk edge that samples x_q=0, x=1.
- **Command priority each cycle:** clear edge > stop edge > start edge. load is evaluated independently, in IDLE/PAUSE only.
- **FSM transitions:**
  - Any state + clear edge → IDLE; led=0; prescaler=0; no carry.
  - IDLE + start → RUN; prescaler=0.
  - RUN + stop → PAUSE; prescaler held.
  - PAUSE + start → RUN; prescaler resumes from its held value, so no phase loss.
  - IDLE + stop: no effect.
  - RUN + start: no effect.
  - start and stop edges in the same cycle: stop wins. RUN → PAUSE; IDLE/PAUSE unchanged.
- **Prescaler:**
  - Counts only in RUN.
  - tick = (prescaler == DIV-1); on tick, prescaler → 0.
  - With DIV=1, tick every RUN cycle.
  - First step after IDLE→RUN at edge E0 occurs at edge E0+DIV.
- **Count on tick:**
  - dir=1: led+1, or 0 with carry=1 if led==MOD-1.
  - dir=0: led-1, or MOD-1 with carry=1 if led==0.
  - carry is high only during the cycle following the update edge.
  - dir changes take effect at the next tick.
- **Tick coincident with stop edge:** the step is applied, then state=PAUSE, prescaler=0.
- **Tick coincident with clear edge:** clear wins; led=0, no carry.
- **Load:**
  - In IDLE/PAUSE with load=1 and load_val<MOD: led=load_val at that edge; state and prescaler unchanged.
  - load_val ≥ MOD: led unchanged, load_err pulses 1 cycle.
  - load in RUN: ignored, no error.
  - load and clear edge in the same cycle: clear wins.
- **Reset mid-RUN:** immediate return to reset values. After release, the FSM stays in IDLE until a new start edge.
- All outputs are registered; no combinational input→output paths.

Test Plan:
- **Reset and start:** reset low 20 ns, release; raise start after 2 cycles, DIV=4, dir=1, 20 ns clk → state=01; led goes 1,2,3… every 80 ns; 11→0 with carry=1 for exactly 1 cycle; 12 steps back to 0.
- **Pause and resume:** stop edge when led=5 with prescaler at 2 → state=10, led stays 5 for 10 cycles; start edge → led=6 exactly 2 cycles later (phase preserved).
- **Down count:** dir=0 from led=1 → led=0, then 11 with carry=1, then 10.
- **Load:** in PAUSE, load=1 with load_val=9 → led=9, no load_err; load_val=12 → led unchanged, load_err=1 for 1 cycle; load=1 in RUN → ignored.
- **Simultaneous events:** clear edge on a tick cycle at led=11 → led=0, carry=0, state=00; start+stop edges together in RUN → state=10.
- **Async reset mid-RUN:** assert reset between clk edges at led=7 → led=0, state=00 before the next clk edge; start held high across release → one RUN entry only.
